// File: rtl/rd_resp_pkg.sv
// ============================================================================
// Module   : rd_resp_pkg
// Purpose  : Shared widths, payload layouts and helpers for the read responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef ADDR_LENTH
`define ADDR_LENTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package rd_resp_pkg;

    localparam int LEN_W       = 8;
    localparam int DST_W       = 4;
    localparam int DFLT_ADDR_W = `ADDR_LENTH;
    localparam int DFLT_DATA_W = `DATA_WIDTH;

    // Command payload layout as carried on the read-command channel
    typedef struct packed {
        logic [DFLT_ADDR_W-1:0] addr;
        logic [LEN_W-1:0]       len;
        logic                   drop;
    } rd_cmd_t;

    typedef struct packed {
        logic [DFLT_DATA_W-1:0] data;
        logic                   last;
    } rd_beat_t;

    function automatic logic is_last(input logic [LEN_W-1:0] cnt,
                                     input logic [LEN_W-1:0] len);
        return (cnt == len);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rd_resp_fifo.sv
// ============================================================================
// Module   : rd_resp_fifo
// Purpose  : Synchronous response FIFO with occupancy output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rd_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             w_push;
    logic             w_pop;

    assign w_push = push_i && (count_q != CW'(DEPTH));
    assign w_pop  = pop_i  && (count_q != '0);

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/rd_cmd_responder.sv
// ============================================================================
// Module   : rd_cmd_responder
// Purpose  : Turns read commands into SRAM read bursts and streams tagged beats.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef ADDR_LENTH
`define ADDR_LENTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module rd_cmd_responder
    import rd_resp_pkg::*;
#(
    parameter int ADDR_W     = `ADDR_LENTH,
    parameter int DATA_W     = `DATA_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic                    iRdCmdInVld,
    output logic                    oRdCmdInRdy,
    input  logic [ADDR_W+LEN_W:0]   iRdCmdInPld,
    input  logic [DST_W-1:0]        iRdCmdInDst,
    output logic                    oRdDataOutVld,
    input  logic                    iRdDataOutRdy,
    output logic [DATA_W:0]         oRdDataOutPld,
    output logic [DST_W-1:0]        oRdDataOutDst,
    output logic                    oMemRdEn,
    output logic [ADDR_W-1:0]       oMemAddr,
    input  logic [DATA_W-1:0]       iMemRdData,
    output logic                    oFreeVld,
    output logic [ADDR_W-1:0]       oFreeAddr,
    output logic [LEN_W-1:0]        oFreeLen
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_READ = 1'b1;
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = DATA_W + 1 + DST_W;

    logic [0:0]        state_q,     state_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;
    logic [LEN_W-1:0]  len_q,       len_d;
    logic [DST_W-1:0]  dst_q,       dst_d;
    logic [LEN_W-1:0]  cnt_q,       cnt_d;
    logic              infl_q,      infl_d;
    logic              infl_last_q, infl_last_d;
    logic [DST_W-1:0]  infl_dst_q,  infl_dst_d;
    logic              free_vld_q,  free_vld_d;
    logic [ADDR_W-1:0] free_addr_q, free_addr_d;
    logic [LEN_W-1:0]  free_len_q,  free_len_d;

    logic [ADDR_W-1:0]  w_cmd_addr;
    logic [LEN_W-1:0]   w_cmd_len;
    logic               w_cmd_drop;
    logic               w_accept;
    logic               w_issue;
    logic               w_issue_last;
    logic [CW-1:0]      w_fifo_count;
    logic [CW-1:0]      w_credit_used;
    logic               w_fifo_empty;
    logic [ENTRY_W-1:0] w_fifo_head;
    logic               w_pop;

    assign w_cmd_addr = iRdCmdInPld[ADDR_W+LEN_W:LEN_W+1];
    assign w_cmd_len  = iRdCmdInPld[LEN_W:1];
    assign w_cmd_drop = iRdCmdInPld[0];

    assign oRdCmdInRdy = (state_q == ST_IDLE);
    assign w_accept    = iRdCmdInVld && oRdCmdInRdy;

    // A read may only issue if its word is guaranteed a FIFO slot on return
    assign w_credit_used = w_fifo_count + CW'(infl_q);
    assign w_issue       = (state_q == ST_READ) && (w_credit_used < CW'(FIFO_DEPTH));
    assign w_issue_last  = is_last(cnt_q, len_q);

    assign oMemRdEn = w_issue;
    assign oMemAddr = addr_q + ADDR_W'(cnt_q);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        dst_d       = dst_q;
        cnt_d       = cnt_q;
        free_vld_d  = 1'b0;
        free_addr_d = free_addr_q;
        free_len_d  = free_len_q;
        infl_d      = w_issue;
        infl_last_d = w_issue && w_issue_last;
        infl_dst_d  = dst_q;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_cmd_drop) begin
                        free_vld_d  = 1'b1;
                        free_addr_d = w_cmd_addr;
                        free_len_d  = w_cmd_len;
                    end else begin
                        state_d = ST_READ;
                        addr_d  = w_cmd_addr;
                        len_d   = w_cmd_len;
                        dst_d   = iRdCmdInDst;
                        cnt_d   = '0;
                    end
                end
            end
            ST_READ: begin
                if (w_issue) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (w_issue_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            dst_q       <= '0;
            cnt_q       <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            infl_dst_q  <= '0;
            free_vld_q  <= 1'b0;
            free_addr_q <= '0;
            free_len_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            dst_q       <= dst_d;
            cnt_q       <= cnt_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            infl_dst_q  <= infl_dst_d;
            free_vld_q  <= free_vld_d;
            free_addr_q <= free_addr_d;
            free_len_q  <= free_len_d;
        end
    end

    assign oFreeVld  = free_vld_q;
    assign oFreeAddr = free_addr_q;
    assign oFreeLen  = free_len_q;

    assign w_pop = oRdDataOutVld && iRdDataOutRdy;

    rd_resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_i   (iClk),
        .rst_i   (iRst),
        .push_i  (infl_q),
        .data_i  ({iMemRdData, infl_last_q, infl_dst_q}),
        .pop_i   (w_pop),
        .data_o  (w_fifo_head),
        .empty_o (w_fifo_empty),
        .count_o (w_fifo_count)
    );

    assign oRdDataOutVld = !w_fifo_empty;
    assign oRdDataOutPld = w_fifo_head[ENTRY_W-1:DST_W];
    assign oRdDataOutDst = w_fifo_head[DST_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_rd_cmd_responder.sv
// ============================================================================
// Module   : tb_rd_cmd_responder
// Purpose  : Directed self-checking bench for rd_cmd_responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rd_cmd_responder;
    import rd_resp_pkg::*;

    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_vld = 1'b0;
    logic          cmd_rdy;
    logic [AW+8:0] cmd_pld = '0;
    logic [3:0]    cmd_dst = '0;
    logic          out_vld;
    logic          out_rdy = 1'b1;
    logic [DW:0]   out_pld;
    logic [3:0]    out_dst;
    logic          rden;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd = '0;
    logic          free_vld;
    logic [AW-1:0] free_addr;
    logic [7:0]    free_len;

    int checks = 0;
    int errors = 0;

    int            cyc = 0;
    logic [AW-1:0] iss_addr[$];
    int            iss_cyc[$];
    logic [20:0]   rx[$];
    int            rx_cyc[$];
    int            out_cnt = 0;
    int            max_out = 0;
    int            ovf = 0;
    int            unstable = 0;
    logic          hold_pend = 1'b0;
    logic [DW:0]   hold_pld = '0;
    logic [3:0]    hold_dst = '0;

    always #5 clk = ~clk;

    rd_cmd_responder #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .iClk          (clk),
        .iRst          (rst),
        .iRdCmdInVld   (cmd_vld),
        .oRdCmdInRdy   (cmd_rdy),
        .iRdCmdInPld   (cmd_pld),
        .iRdCmdInDst   (cmd_dst),
        .oRdDataOutVld (out_vld),
        .iRdDataOutRdy (out_rdy),
        .oRdDataOutPld (out_pld),
        .oRdDataOutDst (out_dst),
        .oMemRdEn      (rden),
        .oMemAddr      (mem_addr),
        .iMemRdData    (mem_rd),
        .oFreeVld      (free_vld),
        .oFreeAddr     (free_addr),
        .oFreeLen      (free_len)
    );

    function automatic logic [DW-1:0] f(input logic [AW-1:0] a);
        return {a ^ 8'h5A, a};
    endfunction

    function automatic logic [20:0] beat(input logic [AW-1:0] a, input logic last,
                                         input logic [3:0] d);
        return {f(a), last, d};
    endfunction

    // SRAM model: data one cycle after the strobe
    always @(posedge clk) begin
        if (rden) mem_rd <= f(mem_addr);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            out_cnt   <= 0;
            hold_pend <= 1'b0;
        end else begin
            if (rden) begin
                iss_addr.push_back(mem_addr);
                iss_cyc.push_back(cyc);
            end
            if (out_vld && out_rdy) begin
                rx.push_back({out_pld, out_dst});
                rx_cyc.push_back(cyc);
            end
            out_cnt <= out_cnt + int'(rden) - int'(out_vld && out_rdy);
            if (out_cnt + int'(rden) - int'(out_vld && out_rdy) > max_out)
                max_out <= out_cnt + int'(rden) - int'(out_vld && out_rdy);
            assert (out_cnt + int'(rden) - int'(out_vld && out_rdy) <= DEPTH)
                else ovf <= ovf + 1;
            if (hold_pend && (!out_vld || out_pld !== hold_pld || out_dst !== hold_dst))
                unstable <= unstable + 1;
            hold_pend <= out_vld && !out_rdy;
            hold_pld  <= out_pld;
            hold_dst  <= out_dst;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_cmd(input logic [AW-1:0] a, input logic [7:0] l,
                            input logic d, input logic [3:0] dst);
        logic done;
        done    = 1'b0;
        cmd_vld = 1'b1;
        cmd_pld = rd_cmd_t'{addr: a, len: l, drop: d};
        cmd_dst = dst;
        for (int i = 0; i < 600 && !done; i++) begin
            if (cmd_rdy) done = 1'b1;
            step(1);
        end
        cmd_vld = 1'b0;
        chk("cmd_accept", 64'(done), 64'd1);
    endtask

    initial begin : stim
        int b_i;
        int b_r;
        logic ok;
        logic [AW-1:0] exp_a [6];
        logic [3:0]    exp_d [6];

        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int b_i;
        int b_r;
        logic ok;
        logic [AW-1:0] exp_a [6];
        logic [3:0]    exp_d [6];

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;

        chk("rst_cmd_rdy",  64'(cmd_rdy),   64'd1);
        chk("rst_out_vld",  64'(out_vld),   64'd0);
        chk("rst_rden",     64'(rden),      64'd0);
        chk("rst_mem_addr", 64'(mem_addr),  64'd0);
        chk("rst_free_vld", 64'(free_vld),  64'd0);
        chk("rst_free_addr",64'(free_addr), 64'd0);
        chk("rst_free_len", 64'(free_len),  64'd0);
        step(1);

        // Single beat: strobe at T+1, beat visible at T+3
        send_cmd(8'h10, 8'd0, 1'b0, 4'd5);
        chk("single_rden_t1", 64'(rden),     64'd1);
        chk("single_addr_t1", 64'(mem_addr), 64'h10);
        step(1);
        chk("single_rden_t2", 64'(rden),     64'd0);
        chk("single_vld_t2",  64'(out_vld),  64'd0);
        step(1);
        chk("single_vld_t3",  64'(out_vld),  64'd1);
        chk("single_pld_t3",  64'(out_pld),  64'({f(8'h10), 1'b1}));
        chk("single_dst_t3",  64'(out_dst),  64'd5);
        step(3);

        // Burst with output always ready
        b_i = iss_addr.size();
        b_r = rx.size();
        send_cmd(8'h20, 8'd7, 1'b0, 4'd3);
        step(12);
        chk("burst_issue_cnt", 64'(iss_addr.size() - b_i), 64'd8);
        if (iss_addr.size() >= b_i + 8) begin
            ok = 1'b1;
            for (int i = 0; i < 8; i++) begin
                if (iss_addr[b_i+i] !== 8'(8'h20 + i)) ok = 1'b0;
                if (iss_cyc[b_i+i] != iss_cyc[b_i] + i) ok = 1'b0;
            end
            chk("burst_issue_seq", 64'(ok), 64'd1);
        end
        chk("burst_rx_cnt", 64'(rx.size() - b_r), 64'd8);
        if (rx.size() >= b_r + 8) begin
            for (int i = 0; i < 8; i++)
                chk("burst_beat", 64'(rx[b_r+i]), 64'(beat(8'(8'h20 + i), i == 7, 4'd3)));
            chk("burst_rx_span", 64'(rx_cyc[b_r+7] - rx_cyc[b_r]), 64'd7);
        end

        // Backpressure: toggle, then hold low for 10 cycles
        b_r = rx.size();
        send_cmd(8'h50, 8'd15, 1'b0, 4'd7);
        for (int c = 0; c < 60; c++) begin
            out_rdy = (c < 10) ? (c % 2 == 0) : (c >= 20);
            step(1);
        end
        out_rdy = 1'b1;
        chk("bp_rx_cnt", 64'(rx.size() - b_r), 64'd16);
        if (rx.size() >= b_r + 16) begin
            for (int i = 0; i < 16; i++)
                chk("bp_beat", 64'(rx[b_r+i]), 64'(beat(8'(8'h50 + i), i == 15, 4'd7)));
        end
        chk("bp_max_outstanding", 64'(max_out),  64'd4);
        chk("bp_pld_stable",      64'(unstable), 64'd0);
        chk("bp_no_overflow",     64'(ovf),      64'd0);

        // Drop: free pulse only
        b_i = iss_addr.size();
        b_r = rx.size();
        send_cmd(8'h40, 8'd3, 1'b1, 4'd2);
        chk("drop_free_vld",  64'(free_vld),  64'd1);
        chk("drop_free_addr", 64'(free_addr), 64'h40);
        chk("drop_free_len",  64'(free_len),  64'd3);
        chk("drop_cmd_rdy",   64'(cmd_rdy),   64'd1);
        chk("drop_rden",      64'(rden),      64'd0);
        step(1);
        chk("drop_free_pulse", 64'(free_vld), 64'd0);
        step(6);
        chk("drop_no_issue", 64'(iss_addr.size() - b_i), 64'd0);
        chk("drop_no_beat",  64'(rx.size() - b_r),       64'd0);

        // Address wrap followed by a back-to-back command
        b_i = iss_addr.size();
        b_r = rx.size();
        exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h30, 8'h31};
        exp_d = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd9, 4'd9};
        send_cmd(8'hFE, 8'd3, 1'b0, 4'd4);
        send_cmd(8'h30, 8'd1, 1'b0, 4'd9);
        step(10);
        chk("wrap_issue_cnt", 64'(iss_addr.size() - b_i), 64'd6);
        if (iss_addr.size() >= b_i + 6) begin
            for (int i = 0; i < 6; i++)
                chk("wrap_addr", 64'(iss_addr[b_i+i]), 64'(exp_a[i]));
            chk("wrap_burst1_span", 64'(iss_cyc[b_i+3] - iss_cyc[b_i]),   64'd3);
            chk("wrap_gap",         64'(iss_cyc[b_i+4] - iss_cyc[b_i+3]), 64'd2);
        end
        chk("wrap_rx_cnt", 64'(rx.size() - b_r), 64'd6);
        if (rx.size() >= b_r + 6) begin
            for (int i = 0; i < 6; i++)
                chk("wrap_beat", 64'(rx[b_r+i]), 64'(beat(exp_a[i], (i == 3) || (i == 5), exp_d[i])));
        end

        // Reset during the fourth beat of a long burst
        send_cmd(8'h60, 8'd15, 1'b0, 4'd1);
        step(5);
        chk("rstmid_vld_before", 64'(out_vld), 64'd1);
        rst = 1'b1;
        #1;
        chk("rstmid_out_vld",   64'(out_vld),   64'd0);
        chk("rstmid_rden",      64'(rden),      64'd0);
        chk("rstmid_mem_addr",  64'(mem_addr),  64'd0);
        chk("rstmid_cmd_rdy",   64'(cmd_rdy),   64'd1);
        chk("rstmid_free_addr", 64'(free_addr), 64'd0);
        chk("rstmid_free_len",  64'(free_len),  64'd0);
        step(2);
        rst = 1'b0;
        step(1);
        b_r = rx.size();
        send_cmd(8'h70, 8'd1, 1'b0, 4'd6);
        step(6);
        chk("post_rst_rx_cnt", 64'(rx.size() - b_r), 64'd2);
        if (rx.size() >= b_r + 2) begin
            chk("post_rst_beat0", 64'(rx[b_r]),   64'(beat(8'h70, 1'b0, 4'd6)));
            chk("post_rst_beat1", 64'(rx[b_r+1]), 64'(beat(8'h71, 1'b1, 4'd6)));
        end
        chk("final_no_overflow", 64'(ovf), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rd_cmd_responder.md
# rd_cmd_responder

Memory-side responder for the read-scheduler protocol. It sits between one port of the read-command crossbar output and one packet-buffer SRAM read port. Each accepted read command is turned into a burst of sequential SRAM reads, and the returned words stream back as read-data beats tagged with the requester index. Drop commands skip the SRAM and are retired to the free-address interface.

## Interface
Parameters:
- `ADDR_W`, default `` `ADDR_LENTH ``: SRAM word address width.
- `DATA_W`, default `` `DATA_WIDTH ``: SRAM word / beat width.
- `FIFO_DEPTH`, default 4: response buffer entries; minimum 2, power of two.

Ports:
- `iClk`  in  1  sole clock; all logic on rising edge.
- `iRst`  in  1  asynchronous, active-high reset.
- `iRdCmdIn`  Decoupled.slave  Pld `ADDR_W+9`, Dst 4  read command.
  - Pld = {addr[ADDR_W-1:0], len[7:0], drop}; `len` = beats−1.
  - Dst = requester index.
- `oRdDataOut`  Decoupled.master  Pld `DATA_W+1`, Dst 4  response beat.
  - Pld = {data, last}; Dst echoes the command Dst.
- `oMemRdEn`  out  1  SRAM read strobe.
- `oMemAddr`  out  `ADDR_W`  SRAM read address.
- `iMemRdData`  in  `DATA_W`  SRAM read data, valid exactly 1 cycle after `oMemRdEn`.
- `oFreeVld`  out  1  one-cycle pulse: address range of a dropped command released.
- `oFreeAddr`  out  `ADDR_W`  start address of the dropped command.
- `oFreeLen`  out  8  `len` of the dropped command.

## Operation
- State machine states: `IDLE`, `READ`.
- **IDLE**
  - `iRdCmdIn.Rdy` = 1 only in IDLE.
  - On handshake, latch addr, len, drop and Dst.
  - If drop = 1: pulse `oFreeVld` with the latched addr/len next cycle, stay in IDLE, no SRAM access, no response beat.
  - If drop = 0: go to READ, beat counter = 0.
- **READ**
  - Issue a read (`oMemRdEn` = 1, `oMemAddr` = addr+counter, mod 2^ADDR_W) only when `occupancy + inflight < FIFO_DEPTH`.
  - `inflight` (0/1) = read issued last cycle.
  - When the read with counter == len is issued, return to IDLE.
- **Response capture**
  - Each returned word is pushed into the FIFO with last = (its counter == len) and the latched Dst.
  - Dst/last travel with the in-flight read, so a new command may be accepted while the last word is in flight.
- **FIFO output**
  - `oRdDataOut.Vld` = FIFO non-empty; Pld/Dst = head entry.
  - Pop on Vld & Rdy.
  - Push and pop in the same cycle keep occupancy unchanged.
  - Full cannot occur on push; the credit rule prevents it. Assert this in the bench.
- **Address and length**
  - Addresses wrap from 2^ADDR_W−1 to 0.
  - len = 0 gives 1 beat; len = 255 gives 256 beats.

## Timing
- **Reset values:**
  - Outputs: `iRdCmdIn.Rdy` = 1 after reset; `oRdDataOut.Vld` = 0; `oMemRdEn` = 0; `oMemAddr` = 0; `oFreeVld` = 0; `oFreeAddr` = 0; `oFreeLen` = 0.
  - Internal: FIFO empty, state IDLE.
- **Command latency:** accept at cycle T → first `oMemRdEn` at T+1 → data at T+2 → `oRdDataOut.Vld` at T+3.
- **Throughput:** 1 beat/cycle with Rdy held high and FIFO_DEPTH ≥ 3. FIFO_DEPTH = 2 gives 1 beat per 2 cycles.
- **Back-to-back commands:** the next command is accepted the cycle after the last read issue, giving a 1-cycle gap between bursts.
- **Drop:** `oFreeVld` at T+1. The next command can be accepted at T+1.
- **Backpressure:** `oRdDataOut` Pld/Dst are stable while Vld & !Rdy.
- **Mid-operation reset:** asserting `iRst` aborts the burst, discards in-flight data and FIFO contents, and drops any outstanding free pulse.

## Structure
- Shared package `rd_resp_pkg`:
  - typedef for the command payload struct {addr, len, drop};
  - typedef for the beat struct {data, last};
  - `LEN_W` = 8.
- Sub-module `rd_resp_fifo`: synchronous FIFO with count output; the entry is {beat, Dst}.
- Top level holds the FSM, counter, credit logic and free-pulse register.

## Test plan
- **Single beat:** cmd addr=0x10, len=0, drop=0, Dst=5; `iMemRdData` = f(addr) → one beat, data=f(0x10), last=1, Dst=5, Vld at T+3.
- **Burst, Rdy high:** addr=0x20, len=7 → 8 consecutive beats 0x20..0x27, last only on the 8th, `oMemRdEn` 8 consecutive cycles.
- **Backpressure:** len=15, Rdy toggling 1/0 and held 0 for 10 cycles →
  - no beat lost or duplicated, order preserved;
  - `oMemRdEn` stalls once occupancy + inflight = 4;
  - no FIFO overflow.
- **Drop:** cmd addr=0x40, len=3, drop=1 → `oFreeVld` one cycle with addr 0x40 / len 3, no `oMemRdEn`, no response beat.
- **Wrap and back-to-back:** cmd addr=2^ADDR_W−2, len=3 followed immediately by cmd Dst=9 →
  - addresses …FE, …FF, 0, 1;
  - second burst starts 1 cycle later;
  - Dst switches exactly at the burst boundary.
- **Reset mid-burst:** assert `iRst` during the 4th beat of a len=15 burst → all outputs return to reset values the same cycle; after release, a new cmd completes normally.
